// File: rtl/channel_scan_mask_8x4.sv
`default_nettype none
// ============================================================================
// Module      : channel_scan_mask_8x4
// Description : Time-multiplexing scanner for the 8-way, 4-bit OR-reduction
//               stage. A start request snapshots eight 4-bit channels. The
//               block then presents them one at a time, each for DWELL
//               cycles. On the 32-bit output bus only the selected channel's
//               nibble can be non-zero.
//
// Parameters  : DWELL      cycles each channel is presented (1..16)
//
// Ports       : clk        rising-edge clock
//               rst_n      synchronous active-low reset
//               start      frame request, honoured only while idle
//               stop       abort request, honoured in any state
//               loop       at end of frame: 1 = recapture and rescan,
//                          0 = return to idle
//               din        channel k on din[4k+3:4k]
//               masked     snapshot nibble of presented channel, else 0
//               sel        one-hot presented channel, 0 when idle
//               ch         binary index of presented channel, 0 when idle
//               busy       high while scanning
//               frame_done one-cycle pulse after each completed frame
//
// Revision    : 1.0  initial release
// ============================================================================
module channel_scan_mask_8x4 #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [31:0] din,
    output logic [31:0] masked,
    output logic [7:0]  sel,
    output logic [2:0]  ch,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // Terminal value of the dwell counter for one channel slot.
    localparam logic [3:0] c_DWELL_LAST = 4'(DWELL - 1);

    logic [0:0]  r_state;
    logic [31:0] r_snap;
    logic [2:0]  r_ch;
    logic [3:0]  r_dcnt;
    logic        r_frame_done;

    logic        w_scan;
    logic [4:0]  w_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_snap       <= 32'h0;
            r_ch         <= 3'd0;
            r_dcnt       <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            // frame_done is a pulse: it is set only on the end-of-frame edge.
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_snap  <= din;
                        r_ch    <= 3'd0;
                        r_dcnt  <= 4'd0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (stop) begin
                        // Abort wins over everything, including the final
                        // cycle of a frame, so no frame_done is produced.
                        r_state <= S_IDLE;
                        r_snap  <= 32'h0;
                        r_ch    <= 3'd0;
                        r_dcnt  <= 4'd0;
                    end else if (r_dcnt != c_DWELL_LAST) begin
                        r_dcnt <= r_dcnt + 4'd1;
                    end else if (r_ch != 3'd7) begin
                        r_ch   <= r_ch + 3'd1;
                        r_dcnt <= 4'd0;
                    end else begin
                        r_frame_done <= 1'b1;
                        r_ch         <= 3'd0;
                        r_dcnt       <= 4'd0;
                        if (loop) begin
                            // Back-to-back frame: recapture with no gap.
                            r_snap <= din;
                        end else begin
                            r_state <= S_IDLE;
                            r_snap  <= 32'h0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    assign w_scan     = (r_state == S_SCAN);
    assign w_shift    = {r_ch, 2'b00};
    assign masked     = w_scan ? (r_snap & (32'h0000_000F << w_shift)) : 32'h0;
    assign sel        = w_scan ? (8'h01 << r_ch) : 8'h00;
    assign ch         = r_ch;
    assign busy       = w_scan;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/channel_scan_mask_8x4.md
# channel_scan_mask_8x4

Time-multiplexing scanner that feeds the 8-way, 4-bit OR-reduction stage. On a start request it snapshots eight 4-bit channels and steps through them one at a time, with a programmable dwell. Each cycle it drives a 32-bit bus in which only the selected channel's nibble is non-zero. The downstream OR reduction collapses that bus to the selected channel's 4-bit value.

## Interface
- DWELL, default 4: cycles each channel is presented; legal range 1..16.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- start  in  1  level-sampled request to begin a frame; honoured only in IDLE.
- stop  in  1  abort request; honoured in any state.
- loop  in  1  sampled at end of frame: 1 = recapture and rescan, 0 = return to IDLE.
- din  in  32  channel k occupies din[4k+3:4k], k = 0..7.
- masked  out  32  snapshot nibble k at bits [4k+3:4k], all other bits 0; all 0 when idle.
- sel  out  8  one-hot channel select (sel[k] = 1 when channel k is presented); 0 when idle.
- ch  out  3  binary index of the presented channel; 0 when idle.
- busy  out  1  high in SCAN.
- frame_done  out  1  one-cycle pulse at end of each completed frame.

## Operation
- Registers:
  - snap[31:0]
  - ch[2:0]
  - dwell counter dcnt[3:0]
  - state ∈ {IDLE, SCAN}
  - frame_done flop
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- masked = snap & ({28'b0, 4'hF} << 4·ch) when in SCAN, else 0.
- sel = (8'b1 << ch) when in SCAN, else 0.
- IDLE:
  - start=1 and stop=0: snap ← din, ch ← 0, dcnt ← 0, go to SCAN.
  - Any other input combination: stay in IDLE.
- SCAN, per cycle:
  - stop=1: go to IDLE, clear ch, dcnt and snap. frame_done stays 0, even on the final cycle of a frame. stop overrides every other event.
  - Otherwise, if dcnt ≠ DWELL−1: dcnt ← dcnt+1.
  - Otherwise, if ch ≠ 7: ch ← ch+1, dcnt ← 0.
  - Otherwise (end of frame): frame_done ← 1, ch ← 0, dcnt ← 0.
    - loop=1: snap ← din, stay in SCAN.
    - loop=0: go to IDLE, snap ← 0.
- start while in SCAN is ignored; it neither restarts the frame nor recaptures din.
- din is read only at capture edges. Changes to din mid-frame do not affect masked.
- ch wraps 7→0 only at end of frame; no other wrap path exists.

## Timing
- Reset: when rst_n=0 at an edge, the next state is IDLE with snap=0, ch=0, dcnt=0, frame_done=0. Consequently masked=0, sel=0, ch=0, busy=0, frame_done=0.
- Reset mid-frame is identical to reset; no partial frame resumes.
- Start accepted at edge N:
  - Channel 0 is visible during cycles N+1 .. N+DWELL.
  - Channel k is visible during cycles N+1+k·DWELL .. N+(k+1)·DWELL.
- Frame length is 8·DWELL cycles.
- frame_done is high exactly in cycle N+8·DWELL+1, coincident with either:
  - idle outputs (loop=0), or
  - the new frame's channel 0 (loop=1).
- With loop=1, consecutive frames have no gap cycles.
- With loop=0, a start asserted during the frame_done cycle launches the next frame at that edge: the minimum gap is one idle cycle.
- DWELL=1: ch advances every cycle, and frame_done is visible in cycle N+9.
- stop sampled at edge M: outputs are idle from cycle M+1.

## Test plan
- Basic scan:
  - Stimulus: DWELL=4, din=32'h8765_4321, pulse start, loop=0.
  - Response: masked steps 32'h0000_0001, 32'h0000_0020, …, 32'h8000_0000, each held 4 cycles. sel steps 8'h01 → 8'h80. Downstream OR output reads 1..8. frame_done pulses once in cycle 33 after start, then busy=0 and masked=0.
- Snapshot isolation:
  - Stimulus: start with din=32'hFFFF_FFFF, then set din=0 on the next cycle.
  - Response: every channel shows nibble F for the entire frame.
- Loop mode:
  - Stimulus: loop=1, din changed to 32'h1111_1111 mid-frame.
  - Response: second frame starts with no gap, shows 1 in every nibble, and frame_done pulses every 8·DWELL cycles.
- Stop mid-frame:
  - Stimulus: stop asserted while ch=3.
  - Response: next cycle masked=0, sel=0, busy=0, and no frame_done pulse.
  - Also: start and stop asserted together in IDLE → stays IDLE.
- Reset and ignored start:
  - Stimulus: rst_n=0 for one edge during ch=5.
  - Response: all outputs 0 from the next cycle.
  - Also: start re-pulsed during SCAN → ch sequence unaffected.
- DWELL=1:
  - Response: ch advances every cycle and frame_done pulses 9 cycles after the start edge.
